// File: rtl/sensor_pkg.sv
// sensor_pkg: shared definitions for the delay-chain sensor controller.
//   state_e        - controller FSM states
//   SETTLE_CYC_DEF - default number of discarded cycles after start
//   dw_f()         - width needed to hold a depth value 0..n
package sensor_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_EVAL   = 2'd3
  } state_e;

  localparam int SETTLE_CYC_DEF = 2;

  function automatic int dw_f(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sensor_ctrl_therm_enc.sv
// therm_enc: combinational thermometer decoder for a delay-chain tap word.
//   tap    in  [N_DELAY-1:0] tap word, bit 0 nearest the chain input
//   depth  out [DW-1:0]      index of the first 0 (N_DELAY if all ones)
//   bubble out               a 1 exists somewhere above the first 0
module therm_enc
  import sensor_pkg::*;
#(
  parameter int N_DELAY = 16,
  localparam int DW = dw_f(N_DELAY)
) (
  input  logic [N_DELAY-1:0] tap,
  output logic [DW-1:0]      depth,
  output logic               bubble
);

  logic found;

  always_comb begin
    depth  = DW'(N_DELAY);
    bubble = 1'b0;
    found  = 1'b0;
    for (int i = 0; i < N_DELAY; i++) begin
      // Any 1 seen after the first 0 breaks the thermometer pattern.
      if (found && tap[i]) bubble = 1'b1;
      if (!found && !tap[i]) begin
        depth = DW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sensor_ctrl.sv
// sensor_ctrl: runs one timing measurement per start request. After start it
// discards SETTLE_CYC cycles, then tracks the minimum thermometer depth over
// max(n_samples,1) registered tap words, and reports in a one-cycle EVAL.
//   clk, rst     clock, asynchronous active-high reset
//   start        request a measurement (only honoured in IDLE)
//   n_samples    samples per measurement, 0 means 1 (latched at start)
//   threshold    minimum acceptable depth (latched at start)
//   taps         captured delay-chain tap word
//   alarm_clr    clears the sticky alarm
//   busy         not in IDLE
//   done         one-cycle pulse when results update
//   min_depth    minimum depth of the last completed measurement
//   bubble       last measurement saw a non-thermometer word
//   alarm        sticky: some measurement had min_depth < threshold
module sensor_ctrl
  import sensor_pkg::*;
#(
  parameter int N_DELAY    = 16,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  localparam int DW = dw_f(N_DELAY)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         n_samples,
  input  logic [DW-1:0]      threshold,
  input  logic [N_DELAY-1:0] taps,
  input  logic               alarm_clr,
  output logic               busy,
  output logic               done,
  output logic [DW-1:0]      min_depth,
  output logic               bubble,
  output logic               alarm
);

  // One counter serves both SETTLE and SAMPLE phases.
  localparam int CW = (dw_f(SETTLE_CYC) > 4) ? dw_f(SETTLE_CYC) : 4;

  state_e               state;
  logic [CW-1:0]        cnt;
  logic [3:0]           n_lat;
  logic [DW-1:0]        thr_lat;
  logic [N_DELAY-1:0]   tap_q;
  logic [DW-1:0]        run_min;
  logic                 run_bub;
  logic [DW-1:0]        enc_depth;
  logic                 enc_bub;

  therm_enc #(.N_DELAY(N_DELAY)) u_enc (
    .tap    (tap_q),
    .depth  (enc_depth),
    .bubble (enc_bub)
  );

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      n_lat     <= '0;
      thr_lat   <= '0;
      tap_q     <= '0;
      run_min   <= DW'(N_DELAY);
      run_bub   <= 1'b0;
      min_depth <= DW'(N_DELAY);
      bubble    <= 1'b0;
      alarm     <= 1'b0;
      done      <= 1'b0;
    end else begin
      tap_q <= taps;
      done  <= 1'b0;
      // A set in EVAL below overrides this clear.
      if (alarm_clr) alarm <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            n_lat   <= (n_samples == 4'd0) ? 4'd1 : n_samples;
            thr_lat <= threshold;
            cnt     <= '0;
            run_min <= DW'(N_DELAY);
            run_bub <= 1'b0;
            state   <= (SETTLE_CYC == 0) ? S_SAMPLE : S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt == CW'(SETTLE_CYC - 1)) begin
            cnt     <= '0;
            run_min <= DW'(N_DELAY);
            run_bub <= 1'b0;
            state   <= S_SAMPLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_SAMPLE: begin
          run_min <= (enc_depth < run_min) ? enc_depth : run_min;
          run_bub <= run_bub | enc_bub;
          if (cnt == CW'(n_lat - 4'd1)) begin
            cnt   <= '0;
            state <= S_EVAL;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_EVAL: begin
          min_depth <= run_min;
          bubble    <= run_bub;
          if (run_min < thr_lat) alarm <= 1'b1;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_ctrl.sv
// Self-checking bench for sensor_ctrl (defaults N_DELAY=16, SETTLE_CYC=2).
// Expected results go into a queue at start and are compared when done pulses.
module tb_sensor_ctrl;
  localparam int N  = 16;
  localparam int DW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    n_samples = '0;
  logic [DW-1:0] threshold = '0;
  logic [N-1:0]  taps = '0;
  logic          alarm_clr = 1'b0;
  logic          busy, done, bubble, alarm;
  logic [DW-1:0] min_depth;

  always #5 clk = ~clk;

  sensor_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n_samples (n_samples),
    .threshold (threshold),
    .taps      (taps),
    .alarm_clr (alarm_clr),
    .busy      (busy),
    .done      (done),
    .min_depth (min_depth),
    .bubble    (bubble),
    .alarm     (alarm)
  );

  typedef struct {
    logic [DW-1:0] md;
    logic          bub;
    logic          al;
  } exp_t;

  typedef struct {
    logic [3:0]    n;
    logic [DW-1:0] thr;
    logic [N-1:0]  w;
    logic [DW-1:0] md;
    logic          bub;
    logic          al;
  } vec_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   n_done = 0;
  int   n_exp  = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      n_done++;
      chk("done_single_cycle", int'(prev_done), 0);
      if (sbq.size() == 0) begin
        chk("done_unexpected", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("min_depth", int'(min_depth), int'(e.md));
        chk("bubble", int'(bubble), int'(e.bub));
        chk("alarm", int'(alarm), int'(e.al));
      end
    end
    prev_done = done;
  end

  // Word k of w is presented in cycle k after start (k=0 with start itself).
  task automatic run_meas(input logic [3:0] n, input logic [DW-1:0] thr,
                          input logic [N-1:0] w[8], input int restart_k,
                          input exp_t e, input string tag);
    int lat;
    int nn;
    nn = (n == 4'd0) ? 1 : int'(n);
    @(posedge clk); #1;
    start = 1'b1; n_samples = n; threshold = thr; taps = w[0];
    sbq.push_back(e); n_exp++;
    lat = 0;
    do begin
      @(posedge clk); lat++; #1;
      start = (lat == restart_k);
      taps  = (lat < 8) ? w[lat] : w[7];
      if (lat == 1) chk({tag, "_busy"}, int'(busy), 1);
    end while (!done && lat < 40);
    start = 1'b0;
    chk({tag, "_latency"}, lat, 1 + 2 + nn + 1);
    chk({tag, "_busy_at_done"}, int'(busy), 0);
  endtask

  task automatic clr_alarm();
    @(posedge clk); #1 alarm_clr = 1'b1;
    @(posedge clk); #1 alarm_clr = 1'b0;
  endtask

  vec_t         tbl[10];
  logic [N-1:0] wa[8];
  exp_t         ex;

  initial begin
    tbl[0] = '{4'd4,  5'd10, 16'h00FF, 5'd8,  1'b0, 1'b1};
    tbl[1] = '{4'd1,  5'd0,  16'h0F0F, 5'd4,  1'b1, 1'b0};
    tbl[2] = '{4'd0,  5'd0,  16'h0F0F, 5'd4,  1'b1, 1'b0};
    tbl[3] = '{4'd3,  5'd16, 16'hFFFF, 5'd16, 1'b0, 1'b0};
    tbl[4] = '{4'd2,  5'd1,  16'h0000, 5'd0,  1'b0, 1'b1};
    tbl[5] = '{4'd2,  5'd0,  16'h0000, 5'd0,  1'b0, 1'b0};
    tbl[6] = '{4'd15, 5'd15, 16'h7FFF, 5'd15, 1'b0, 1'b0};
    tbl[7] = '{4'd1,  5'd5,  16'h8000, 5'd0,  1'b1, 1'b1};
    tbl[8] = '{4'd5,  5'd2,  16'h0001, 5'd1,  1'b0, 1'b1};
    tbl[9] = '{4'd1,  5'd0,  16'hFFFE, 5'd0,  1'b1, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_min_depth", int'(min_depth), 16);
    chk("rst_bubble", int'(bubble), 0);
    chk("rst_alarm", int'(alarm), 0);
    rst = 1'b0;

    // Table: constant tap word per measurement, alarm cleared between runs
    for (int i = 0; i < 10; i++) begin
      foreach (wa[j]) wa[j] = tbl[i].w;
      ex = '{tbl[i].md, tbl[i].bub, tbl[i].al};
      run_meas(tbl[i].n, tbl[i].thr, wa, -1, ex, $sformatf("vec%0d", i));
      clr_alarm();
    end

    // Settle-cycle words (0000) must be discarded
    wa = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0FFF,
           16'h3FFF, 16'h00FF, 16'h0000, 16'h0000};
    ex = '{5'd8, 1'b0, 1'b0};
    run_meas(4'd4, 5'd0, wa, -1, ex, "settle_discard");

    // Second start mid-measurement is ignored
    foreach (wa[j]) wa[j] = 16'h00FF;
    ex = '{5'd8, 1'b0, 1'b0};
    run_meas(4'd4, 5'd0, wa, 3, ex, "restart_ignored");
    repeat (15) @(posedge clk);

    // Reset mid-SAMPLE after an alarming measurement
    ex = '{5'd8, 1'b0, 1'b1};
    run_meas(4'd4, 5'd10, wa, -1, ex, "pre_reset");
    @(posedge clk); #1;
    start = 1'b1; n_samples = 4'd8; threshold = 5'd0; taps = 16'h00FF;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_min_depth", int'(min_depth), 16);
    chk("abort_alarm", int'(alarm), 0);
    rst = 1'b0;
    repeat (15) @(posedge clk);

    // Clear held across a violating EVAL: set wins, later clear works
    ex = '{5'd8, 1'b0, 1'b1};
    run_meas(4'd4, 5'd10, wa, -1, ex, "alarm_set");
    alarm_clr = 1'b1;
    foreach (wa[j]) wa[j] = 16'h0000;
    ex = '{5'd0, 1'b0, 1'b1};
    run_meas(4'd2, 5'd1, wa, -1, ex, "clr_vs_set");
    @(posedge clk); #1;
    chk("alarm_after_clr", int'(alarm), 0);
    alarm_clr = 1'b0;

    repeat (5) @(posedge clk);
    chk("done_count", n_done, n_exp);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
